// File: rtl/line_dispatcher.sv
// Command-side initiator for the line rasterizer: buffers line commands in a FIFO,
// drops wholly off-screen lines and hands the rest to the rasterizer one at a time.
module line_dispatcher #(
   parameter int DEPTH = 16,
   parameter int CW    = 13
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      cmd_valid,
   output logic                      cmd_ready,
   input  logic signed [CW-1:0]      cmd_sx,
   input  logic signed [CW-1:0]      cmd_sy,
   input  logic signed [CW-1:0]      cmd_ex,
   input  logic signed [CW-1:0]      cmd_ey,
   input  logic [3:0]                cmd_color,
   input  logic                      cmd_last,
   output logic signed [CW-1:0]      startX,
   output logic signed [CW-1:0]      startY,
   output logic signed [CW-1:0]      endX,
   output logic signed [CW-1:0]      endY,
   output logic [3:0]                lineColor,
   output logic                      readyIn,
   input  logic                      rastReady,
   input  logic                      done,
   output logic                      busy,
   output logic                      frame_done,
   output logic [15:0]               line_count,
   output logic [15:0]               cull_count,
   output logic [15:0]               last_frame_lines,
   output logic [$clog2(DEPTH):0]    fifo_level,
   output logic [1:0]                dbg_state
);

   // Handshakes: a command is taken on cmd_valid & cmd_ready at the clock edge;
   // a line is handed over on readyIn & rastReady at the clock edge, after which
   // the dispatcher waits for the single-cycle done pulse before popping again.

   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;
   localparam int EW = 4 * CW + 5;

   localparam logic signed [CW-1:0] X_LO = CW'(-320);
   localparam logic signed [CW-1:0] X_HI = CW'(319);
   localparam logic signed [CW-1:0] Y_LO = CW'(-239);
   localparam logic signed [CW-1:0] Y_HI = CW'(240);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2
   } state_t;

   state_t state, state_next;

   logic [EW-1:0]          mem [DEPTH];
   logic [AW-1:0]          wr_ptr, rd_ptr;
   logic [LW-1:0]          level_next;
   logic                   push, pop;
   logic signed [CW-1:0]   h_sx, h_sy, h_ex, h_ey;
   logic [3:0]             h_color;
   logic                   h_last;
   logic                   culled;
   logic                   load, cull, count_line;
   logic                   cur_last;

   assign push = cmd_valid && cmd_ready;
   assign {h_sx, h_sy, h_ex, h_ey, h_color, h_last} = mem[rd_ptr];

   assign culled = (h_sx < X_LO && h_ex < X_LO) || (h_sx > X_HI && h_ex > X_HI) ||
                   (h_sy < Y_LO && h_ey < Y_LO) || (h_sy > Y_HI && h_ey > Y_HI);

   always_comb begin
      level_next = fifo_level;
      if (push && !pop)
         level_next = fifo_level + LW'(1);
      else if (pop && !push)
         level_next = fifo_level - LW'(1);
   end

   always_ff @(posedge clk) begin
      if (push)
         mem[wr_ptr] <= {cmd_sx, cmd_sy, cmd_ex, cmd_ey, cmd_color, cmd_last};
   end

   // cmd_ready is registered from the next level so it is low throughout reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fifo_level <= '0;
         cmd_ready  <= 1'b0;
      end else begin
         if (push)
            wr_ptr <= wr_ptr + AW'(1);
         if (pop)
            rd_ptr <= rd_ptr + AW'(1);
         fifo_level <= level_next;
         cmd_ready  <= (level_next != LW'(DEPTH));
      end
   end

   always_ff @(posedge clk) begin
      if (rst)
         state <= IDLE;
      else
         state <= state_next;
   end

   always_comb begin
      state_next = state;
      pop        = 1'b0;
      load       = 1'b0;
      cull       = 1'b0;
      count_line = 1'b0;
      frame_done = 1'b0;
      if (!rst) begin
         case (state)
            IDLE: begin
               if (fifo_level != '0) begin
                  pop = 1'b1;
                  if (culled) begin
                     cull       = 1'b1;
                     frame_done = h_last;
                  end else begin
                     load       = 1'b1;
                     state_next = ISSUE;
                  end
               end
            end
            ISSUE: begin
               if (rastReady) begin
                  count_line = 1'b1;
                  state_next = WAIT;
               end
            end
            WAIT: begin
               if (done) begin
                  frame_done = cur_last;
                  state_next = IDLE;
               end
            end
            default: state_next = IDLE;
         endcase
      end
   end

   assign readyIn   = (state == ISSUE);
   assign busy      = (state != IDLE) || (fifo_level != '0);
   assign dbg_state = state;

   always_ff @(posedge clk) begin
      if (rst) begin
         startX    <= '0;
         startY    <= '0;
         endX      <= '0;
         endY      <= '0;
         lineColor <= '0;
         cur_last  <= 1'b0;
      end else if (load) begin
         startX    <= h_sx;
         startY    <= h_sy;
         endX      <= h_ex;
         endY      <= h_ey;
         lineColor <= h_color;
         cur_last  <= h_last;
      end
   end

   // The frame boundary wins over any increment in the same cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         line_count       <= '0;
         cull_count       <= '0;
         last_frame_lines <= '0;
      end else if (frame_done) begin
         last_frame_lines <= line_count;
         line_count       <= '0;
         cull_count       <= '0;
      end else begin
         if (count_line && line_count != 16'hFFFF)
            line_count <= line_count + 16'd1;
         if (cull && cull_count != 16'hFFFF)
            cull_count <= cull_count + 16'd1;
      end
   end

endmodule

// File: tb/tb_line_dispatcher.sv
// Bench for line_dispatcher: directed scenarios plus randomized traffic against
// a queue-based model of which lines reach the rasterizer and per-frame statistics.
module tb_line_dispatcher;

   localparam int DEPTH = 16;
   localparam int CW    = 13;
   localparam int LW    = 4 * CW + 4;

   logic                   clk = 1'b0;
   logic                   rst;
   logic                   cmd_valid;
   logic                   cmd_ready;
   logic signed [CW-1:0]   cmd_sx, cmd_sy, cmd_ex, cmd_ey;
   logic [3:0]             cmd_color;
   logic                   cmd_last;
   logic signed [CW-1:0]   startX, startY, endX, endY;
   logic [3:0]             lineColor;
   logic                   readyIn;
   logic                   rastReady;
   logic                   done;
   logic                   busy;
   logic                   frame_done;
   logic [15:0]            line_count, cull_count, last_frame_lines;
   logic [$clog2(DEPTH):0] fifo_level;
   logic [1:0]             dbg_state;

   int n_cmp = 0;
   int n_err = 0;

   logic [LW-1:0] exp_q[$];
   int            frame_vis_q[$];
   int            frame_cull_q[$];
   int            frm_vis = 0;
   int            frm_cull = 0;
   bit            mon_en = 0;
   bit            lfl_pend = 0;
   int            lfl_exp = 0;
   bit            auto_rast = 0;

   line_dispatcher #(.DEPTH(DEPTH), .CW(CW)) dut (
      .clk(clk), .rst(rst),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_sx(cmd_sx), .cmd_sy(cmd_sy), .cmd_ex(cmd_ex), .cmd_ey(cmd_ey),
      .cmd_color(cmd_color), .cmd_last(cmd_last),
      .startX(startX), .startY(startY), .endX(endX), .endY(endY),
      .lineColor(lineColor), .readyIn(readyIn), .rastReady(rastReady), .done(done),
      .busy(busy), .frame_done(frame_done),
      .line_count(line_count), .cull_count(cull_count),
      .last_frame_lines(last_frame_lines), .fifo_level(fifo_level),
      .dbg_state(dbg_state)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // A line is drawable unless both endpoints sit beyond the same screen edge.
   function automatic bit is_visible(input int sx, input int sy, input int ex, input int ey);
      if (sx < -320 && ex < -320) return 0;
      if (sx > 319 && ex > 319) return 0;
      if (sy < -239 && ey < -239) return 0;
      if (sy > 240 && ey > 240) return 0;
      return 1;
   endfunction

   // Scoreboard: model pushes, dispatches and frame boundaries seen on the ports.
   always @(negedge clk) begin
      if (mon_en) begin
         if (rst) begin
            exp_q.delete();
            frame_vis_q.delete();
            frame_cull_q.delete();
            frm_vis  = 0;
            frm_cull = 0;
            lfl_pend = 0;
         end else begin
            if (lfl_pend) begin
               check("last_frame_lines", last_frame_lines, lfl_exp);
               check("line_count_clr", line_count, 0);
               check("cull_count_clr", cull_count, 0);
               lfl_pend = 0;
            end
            if (cmd_valid && cmd_ready) begin
               if (is_visible(cmd_sx, cmd_sy, cmd_ex, cmd_ey)) begin
                  exp_q.push_back({cmd_sx, cmd_sy, cmd_ex, cmd_ey, cmd_color});
                  frm_vis++;
               end else if (!cmd_last) begin
                  frm_cull++;
               end
               if (cmd_last) begin
                  frame_vis_q.push_back(frm_vis);
                  frame_cull_q.push_back(frm_cull);
                  frm_vis  = 0;
                  frm_cull = 0;
               end
            end
            if (readyIn && rastReady) begin
               if (exp_q.size() == 0)
                  check("dispatch_unexpected", 1, 0);
               else
                  check("dispatch", {startX, startY, endX, endY, lineColor}, exp_q.pop_front());
            end
            if (frame_done) begin
               if (frame_vis_q.size() == 0) begin
                  check("frame_unexpected", 1, 0);
               end else begin
                  lfl_exp = frame_vis_q.pop_front();
                  check("frame_lines", line_count, lfl_exp);
                  check("frame_culls", cull_count, frame_cull_q.pop_front());
                  lfl_pend = 1;
               end
            end
         end
      end
   end

   // Rasterizer stand-in: idle until a handshake, then done after a random latency.
   initial begin
      rastReady = 1'b0;
      done      = 1'b0;
      forever begin
         @(negedge clk);
         if (auto_rast && readyIn && rastReady) begin
            @(posedge clk);
            #1 rastReady = 1'b0;
            repeat ($urandom_range(1, 5)) @(posedge clk);
            #1 done = 1'b1;
            @(posedge clk);
            #1 done = 1'b0;
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1 rastReady = 1'b1;
         end
      end
   end

   task automatic push_cmd(input int sx, input int sy, input int ex, input int ey,
                           input int color, input bit last);
      bit ok = 0;
      cmd_sx    = CW'(sx);
      cmd_sy    = CW'(sy);
      cmd_ex    = CW'(ex);
      cmd_ey    = CW'(ey);
      cmd_color = 4'(color);
      cmd_last  = last;
      cmd_valid = 1'b1;
      for (int i = 0; i < 400; i++) begin
         @(negedge clk);
         if (cmd_ready) begin
            ok = 1;
            break;
         end
      end
      @(posedge clk);
      #1 cmd_valid = 1'b0;
      if (!ok) check("push_timeout", 0, 1);
   endtask

   task automatic wait_idle();
      bit ok = 0;
      for (int i = 0; i < 3000; i++) begin
         @(negedge clk);
         if (!busy) begin
            ok = 1;
            break;
         end
      end
      @(posedge clk);
      #1;
      if (!ok) check("idle_timeout", 0, 1);
   endtask

   // Manual rasterizer: take one line, then return done; ends in the IDLE cycle.
   task automatic serve_one();
      bit ok = 0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (readyIn) begin
            ok = 1;
            break;
         end
      end
      if (!ok) check("serve_timeout", 0, 1);
      rastReady = 1'b1;
      @(posedge clk);
      #1 rastReady = 1'b0;
      repeat (2) @(posedge clk);
      #1 done = 1'b1;
      @(posedge clk);
      #1 done = 1'b0;
   endtask

   function automatic int rand_coord(input bit is_x);
      if ($urandom_range(0, 3) == 0) begin
         case ($urandom_range(0, 3))
            0:       return is_x ? -321 : -240;
            1:       return is_x ? -320 : -239;
            2:       return is_x ? 319 : 240;
            default: return is_x ? 320 : 241;
         endcase
      end
      return int'($urandom_range(0, 1400)) - 700;
   endfunction

   function automatic int rand_end(input int s, input bit is_x);
      if ($urandom_range(0, 1) == 0) return s + int'($urandom_range(0, 10)) - 5;
      return rand_coord(is_x);
   endfunction

   initial begin
      int hold_ok;
      int accepted;
      int sx, sy, ex, ey;

      rst       = 1'b1;
      cmd_valid = 1'b0;
      cmd_sx = '0; cmd_sy = '0; cmd_ex = '0; cmd_ey = '0;
      cmd_color = '0;
      cmd_last  = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_readyIn", readyIn, 0);
      check("rst_cmd_ready", cmd_ready, 0);
      check("rst_fifo_level", fifo_level, 0);
      check("rst_busy", busy, 0);
      check("rst_counts", {line_count, cull_count, last_frame_lines}, 0);
      check("rst_state", dbg_state, 0);
      rst = 1'b0;
      mon_en = 1;
      @(posedge clk);
      #1 check("cmd_ready_rise", cmd_ready, 1);

      // Single visible line, last of its frame.
      push_cmd(-25, 50, 75, 250, 7, 1);
      check("t1_level", fifo_level, 1);
      @(posedge clk);
      #1;
      check("t1_readyIn", readyIn, 1);
      check("t1_startX", startX, CW'(-25));
      check("t1_endY", endY, CW'(250));
      check("t1_color", lineColor, 7);
      rastReady = 1'b1;
      @(posedge clk);
      #1 rastReady = 1'b0;
      check("t1_wait_state", dbg_state, 2);
      check("t1_wait_readyIn", readyIn, 0);
      check("t1_line_count", line_count, 1);
      done = 1'b1;
      #1 check("t1_frame_done", frame_done, 1);
      @(posedge clk);
      #1 done = 1'b0;
      check("t1_lfl", last_frame_lines, 1);
      check("t1_lc_zero", line_count, 0);

      // Three lines queued behind a stalled rasterizer.
      push_cmd(10, 10, 20, 20, 1, 0);
      push_cmd(30, 30, 40, 40, 2, 0);
      push_cmd(50, 50, 60, 60, 3, 1);
      hold_ok = 0;
      for (int i = 0; i < 20; i++) begin
         if (readyIn && startX == CW'(10) && fifo_level == 2) hold_ok++;
         @(posedge clk);
         #1;
      end
      check("t2_hold", hold_ok, 20);
      rastReady = 1'b1;
      auto_rast = 1;
      wait_idle();
      check("t2_lfl", last_frame_lines, 3);

      // Culled lines never raise readyIn; a culled last line ends the frame.
      push_cmd(-400, 0, -330, 10, 3, 0);
      @(posedge clk);
      #1;
      check("t3_cull_count", cull_count, 1);
      check("t3_no_readyIn", readyIn, 0);
      push_cmd(-400, 0, -330, 10, 3, 1);
      check("t3_frame_done", frame_done, 1);
      check("t3_no_readyIn2", readyIn, 0);
      @(posedge clk);
      #1 check("t3_cull_clr", cull_count, 0);
      push_cmd(-400, 0, 100, 0, 2, 1);
      wait_idle();
      check("t3_crossing_lfl", last_frame_lines, 1);

      // Fill the FIFO behind a stalled rasterizer.
      auto_rast = 0;
      rastReady = 1'b0;
      accepted  = 0;
      for (int i = 0; i < DEPTH + 2; i++) begin
         cmd_sx = CW'(i); cmd_sy = CW'(i); cmd_ex = CW'(i + 1); cmd_ey = CW'(i + 2);
         cmd_color = 4'(i);
         cmd_last  = 1'b0;
         cmd_valid = 1'b1;
         @(negedge clk);
         if (cmd_ready) accepted++;
         @(posedge clk);
         #1;
      end
      cmd_valid = 1'b0;
      check("t4_accepted", accepted, DEPTH + 1);
      check("t4_level_full", fifo_level, DEPTH);
      check("t4_cmd_ready_low", cmd_ready, 0);
      serve_one();
      serve_one();
      check("t4_level_before", fifo_level, DEPTH - 1);
      cmd_sx = CW'(100); cmd_sy = CW'(100); cmd_ex = CW'(110); cmd_ey = CW'(120);
      cmd_color = 4'd9;
      cmd_last  = 1'b0;
      cmd_valid = 1'b1;
      @(posedge clk);
      #1 cmd_valid = 1'b0;
      check("t4_push_pop_level", fifo_level, DEPTH - 1);
      push_cmd(1, 2, 3, 4, 5, 1);
      rastReady = 1'b1;
      auto_rast = 1;
      wait_idle();
      check("t4_lfl", last_frame_lines, DEPTH + 3);

      // Spurious done in IDLE and ISSUE; degenerate on-screen point.
      auto_rast = 0;
      rastReady = 1'b0;
      done = 1'b1;
      #1 check("t6_idle_done_fd", frame_done, 0);
      @(posedge clk);
      #1 done = 1'b0;
      check("t6_idle_state", dbg_state, 0);
      push_cmd(5, 5, 5, 5, 1, 1);
      @(posedge clk);
      #1 done = 1'b1;
      #1 check("t6_issue_done_fd", frame_done, 0);
      @(posedge clk);
      #1 done = 1'b0;
      check("t6_issue_state", dbg_state, 1);
      check("t6_issue_readyIn", readyIn, 1);
      serve_one();
      check("t6_lfl", last_frame_lines, 1);

      // Reset while a line is in flight with four more queued.
      for (int i = 0; i < 5; i++) push_cmd(i * 10, 0, i * 10 + 5, 5, i, 0);
      for (int i = 0; i < 200 && !readyIn; i++) begin
         @(posedge clk);
         #1;
      end
      rastReady = 1'b1;
      @(posedge clk);
      #1 rastReady = 1'b0;
      check("t5_wait_state", dbg_state, 2);
      check("t5_level", fifo_level, 4);
      rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      check("t5_state", dbg_state, 0);
      check("t5_level_clr", fifo_level, 0);
      check("t5_readyIn", readyIn, 0);
      check("t5_counts", {line_count, cull_count}, 0);
      check("t5_busy", busy, 0);
      @(posedge clk);
      #1 check("t5_cmd_ready", cmd_ready, 1);

      // Randomized traffic.
      rastReady = 1'b1;
      auto_rast = 1;
      for (int n = 0; n < 300; n++) begin
         sx = rand_coord(1);
         sy = rand_coord(0);
         ex = rand_end(sx, 1);
         ey = rand_end(sy, 0);
         push_cmd(sx, sy, ex, ey, int'($urandom_range(0, 15)),
                  (n == 299) || ($urandom_range(0, 5) == 0));
         repeat ($urandom_range(0, 3)) begin
            @(posedge clk);
            #1;
         end
      end
      wait_idle();
      repeat (3) @(posedge clk);
      #1;
      check("drained_lines", exp_q.size(), 0);
      check("drained_frames", frame_vis_q.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
